// File: rtl/calc_pkg.sv
// Shared encodings for the calculator: operation codes, FSM states and hex glyphs.
package calc_pkg;

    typedef enum logic [2:0] {
        F_ADD = 3'b000,
        F_SUB = 3'b001,
        F_MUL = 3'b010,
        F_DIV = 3'b011,
        F_AND = 3'b100,
        F_OR  = 3'b101,
        F_XOR = 3'b110,
        F_SHL = 3'b111
    } func_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Active-high segment patterns {g,f,e,d,c,b,a}; entry 15 is listed first.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed hex display: one digit lit at a time, SCAN_DIV clocks each.
module seg_scan
    import calc_pkg::*;
#(
    parameter int NDIG     = 8,
    parameter int SCAN_DIV = 20000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*NDIG-1:0]    value,
    output logic [NDIG-1:0]      led_en,
    output logic [6:0]           seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [CW-1:0] div_cnt;
    logic [DW-1:0] dig;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            dig     <= '0;
        end else if (div_cnt == CW'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            dig     <= (dig == DW'(NDIG - 1)) ? '0 : dig + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Enables and segments are both active-low on the board.
    always_comb begin
        led_en      = '1;
        led_en[dig] = 1'b0;
        seg         = ~seg_glyph(value[4*int'(dig) +: 4]);
    end

endmodule

// File: rtl/calc_seg_engine.sv
// Button-triggered calculator: debounced start, single-cycle and iterative ops,
// result shown in hex on a scanned seven-segment display.
module calc_seg_engine
    import calc_pkg::*;
#(
    parameter int W        = 8,
    parameter int NDIG     = 8,
    parameter int SCAN_DIV = 20000,
    parameter int DEB_CYC  = 200000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            button,
    input  logic [2:0]      func,
    input  logic [W-1:0]    num1,
    input  logic [W-1:0]    num2,
    output logic            busy,
    output logic            err,
    output logic [NDIG-1:0] led_en,
    output logic            led_ca,
    output logic            led_cb,
    output logic            led_cc,
    output logic            led_cd,
    output logic            led_ce,
    output logic            led_cf,
    output logic            led_cg,
    output logic            led_dp
);

    localparam int RW  = 4 * NDIG;
    localparam int PW  = 2 * W;
    localparam int DCW = $clog2(DEB_CYC + 1);
    localparam int IW  = $clog2(W + 1);

    logic           sync1, sync2;
    logic           deb_lvl, lock, start;
    logic [DCW-1:0] deb_cnt;

    state_e         state;
    func_e          op;
    logic [W-1:0]   a_q, b_q, sh, rem;
    logic [PW-1:0]  acc, mc;
    logic [IW-1:0]  itc;
    logic [RW-1:0]  r;

    logic [PW-1:0]  acc_nxt;
    logic [W:0]     shifted, sum, dif;
    logic [W-1:0]   diff, rem_nxt, quo_nxt;
    logic           ge;
    logic [RW-1:0]  res1;
    logic [6:0]     seg;

    // Plain synchroniser on the raw key; no reset so it keeps tracking the pin.
    always_ff @(posedge clk) begin
        sync1 <= button;
        sync2 <= sync1;
    end

    // lock suppresses the start from a key already held when reset lifts;
    // it clears once the key is seen released.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_lvl <= 1'b0;
            deb_cnt <= '0;
            lock    <= 1'b1;
            start   <= 1'b0;
        end else begin
            start <= 1'b0;
            if (!sync2) lock <= 1'b0;
            if (sync2 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DCW'(DEB_CYC - 1)) begin
                deb_lvl <= sync2;
                deb_cnt <= '0;
                start   <= sync2 & ~lock;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        acc_nxt = sh[0] ? acc + mc : acc;
        // Restoring division step: shift in next dividend bit, subtract if it fits.
        shifted = {rem, sh[W-1]};
        ge      = shifted >= {1'b0, b_q};
        diff    = shifted[W-1:0] - b_q;
        rem_nxt = ge ? diff : shifted[W-1:0];
        quo_nxt = {sh[W-2:0], ge};
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} - {1'b0, b_q};
        res1    = '0;
        unique case (op)
            F_ADD: res1 = RW'(sum);
            F_SUB: res1 = {{(RW-W){dif[W]}}, dif[W-1:0]};
            F_MUL: res1 = '0;
            F_DIV: res1 = '1;
            F_AND: res1 = RW'(a_q & b_q);
            F_OR:  res1 = RW'(a_q | b_q);
            F_XOR: res1 = RW'(a_q ^ b_q);
            F_SHL: res1 = RW'(a_q) << b_q[3:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op    <= F_ADD;
            a_q   <= '0;
            b_q   <= '0;
            sh    <= '0;
            rem   <= '0;
            acc   <= '0;
            mc    <= '0;
            itc   <= '0;
            r     <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op    <= func_e'(func);
                        a_q   <= num1;
                        b_q   <= num2;
                        sh    <= (func_e'(func) == F_DIV) ? num1 : num2;
                        mc    <= PW'(num1);
                        acc   <= '0;
                        rem   <= '0;
                        itc   <= '0;
                        err   <= 1'b0;
                        busy  <= (func_e'(func) == F_MUL) ||
                                 (func_e'(func) == F_DIV && num2 != '0);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (busy) begin
                        itc <= itc + 1'b1;
                        if (op == F_MUL) begin
                            acc <= acc_nxt;
                            mc  <= mc << 1;
                            sh  <= sh >> 1;
                        end else begin
                            rem <= rem_nxt;
                            sh  <= quo_nxt;
                        end
                        // Result is committed only with the final iteration.
                        if (itc == IW'(W - 1)) begin
                            busy  <= 1'b0;
                            r     <= (op == F_MUL) ? RW'(acc_nxt) : RW'({quo_nxt, rem_nxt});
                            state <= DONE;
                        end
                    end else begin
                        r     <= res1;
                        err   <= (op == F_DIV);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    seg_scan #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .value  (r),
        .led_en (led_en),
        .seg    (seg)
    );

    assign {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg;
    assign led_dp = 1'b1;

endmodule

// File: tb/tb_calc_seg_engine.sv
// Scoreboard bench: driver pushes model results, monitor checks each completion.
module tb_calc_seg_engine;
    import calc_pkg::*;

    localparam int W = 8, NDIG = 8, SCAN_DIV = 4, DEB_CYC = 3;

    typedef struct {
        logic [31:0] r;
        logic        err;
        int          busy;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, button = 1'b0;
    logic [2:0] func = 3'd0;
    logic [W-1:0] num1 = '0, num2 = '0;
    logic busy, err, led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
    logic [NDIG-1:0] led_en;

    exp_t exp_q[$];
    int n_chk = 0, n_pass = 0, n_done = 0, busy_run = 0;
    state_e last_st = IDLE;
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    calc_seg_engine #(.W(W), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .DEB_CYC(DEB_CYC)) dut (
        .clk(clk), .rst(rst), .button(button), .func(func), .num1(num1), .num2(num2),
        .busy(busy), .err(err), .led_en(led_en),
        .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
        .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic exp_t ref_model(input int f, input int a, input int b);
        exp_t e;
        e.err = 1'b0;
        e.busy = 0;
        case (f)
            0: e.r = a + b;
            1: e.r = a - b;
            2: begin e.r = a * b; e.busy = W; end
            3: if (b == 0) begin e.r = 32'hFFFF_FFFF; e.err = 1'b1; end
               else begin e.r = ((a / b) << 8) | (a % b); e.busy = W; end
            4: e.r = a & b;
            5: e.r = a | b;
            6: e.r = a ^ b;
            default: e.r = a << (b % 16);
        endcase
        return e;
    endfunction

    // Monitor: a fresh entry into DONE is one completed operation.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
            last_st  = IDLE;
        end else begin
            if (busy) busy_run++;
            if (dut.state == DONE && last_st != DONE) begin
                n_done++;
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", 64'(dut.r), 64'(e.r));
                    chk("err", 64'(err), 64'(e.err));
                    chk("busy_cycles", 64'(busy_run), 64'(e.busy));
                end
                busy_run = 0;
            end
            last_st = dut.state;
        end
    end

    task automatic press();
        @(negedge clk); button = 1'b1;
        repeat (6) @(negedge clk);
        button = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic issue(input int f, input int a, input int b);
        func = 3'(f); num1 = 8'(a); num2 = 8'(b);
        exp_q.push_back(ref_model(f, a, b));
        press();
        drain();
    endtask

    task automatic check_reset_state();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_r", 64'(dut.r), 64'd0);
        chk("rst_led_en", 64'(led_en), 64'hFE);
        chk("rst_seg", 64'({led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca}), 64'h40);
    endtask

    // Rebuild the displayed value from the scan and check scan order/dwell.
    task automatic display_check(input logic [31:0] exp_r);
        logic [31:0] got = '0;
        int prev = -1, run = 0, bad = 0, runs = 0;
        repeat (2 * NDIG * SCAN_DIV) begin
            int idx = -1, zeros = 0, nib = -1;
            logic [6:0] pat;
            @(negedge clk);
            for (int i = 0; i < NDIG; i++) if (!led_en[i]) begin idx = i; zeros++; end
            if (led_dp !== 1'b1) bad++;
            if (zeros != 1) bad++;
            else begin
                pat = ~{led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
                for (int j = 0; j < 16; j++) if (glyph[j] == pat) nib = j;
                if (nib < 0) bad++;
                else got[4*idx +: 4] = 4'(nib);
                if (prev >= 0 && idx != prev) begin
                    if (idx != (prev + 1) % NDIG) bad++;
                    if (runs > 0 && run != SCAN_DIV) bad++;
                    runs++;
                    run = 0;
                end
                run++;
                prev = idx;
            end
        end
        chk("disp_value", 64'(got), 64'(exp_r));
        chk("scan_errors", 64'(bad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (4) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        issue(0, 8'hFF, 8'h01);
        display_check(32'h0000_0100);
        issue(2, 8'hFF, 8'hFF);
        display_check(32'h0000_FE01);
        issue(3, 200, 7);
        issue(3, 5, 0);
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        display_check(32'hFFFF_FFFF);
        issue(0, 1, 2);
        issue(1, 3, 5);
        issue(7, 8'h81, 8'h0F);

        // Second press lands inside the mul's EXEC with new operands; it must be dropped.
        n0 = n_done;
        func = 3'd2; num1 = 8'd13; num2 = 8'd11;
        exp_q.push_back(ref_model(2, 13, 11));
        @(negedge clk); button = 1'b1;
        repeat (3) @(negedge clk); button = 1'b0;
        repeat (3) @(negedge clk); button = 1'b1;
        func = 3'd0; num1 = 8'($urandom); num2 = 8'($urandom);
        repeat (5) @(negedge clk); button = 1'b0;
        repeat (8) @(negedge clk);
        drain();
        repeat (10) @(negedge clk);
        chk("double_press_one_done", 64'(n_done), 64'(n0 + 1));

        // Short bounces must not start anything.
        n0 = n_done;
        @(negedge clk); button = 1'b1;
        @(negedge clk); button = 1'b0;
        repeat (8) @(negedge clk); button = 1'b1;
        repeat (2) @(negedge clk); button = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_no_start", 64'(n_done), 64'(n0));
        issue(6, 8'h5A, 8'h3C);
        repeat (10) @(negedge clk);
        chk("stable_one_start", 64'(n_done), 64'(n0 + 1));

        // Key held through reset release must not start.
        button = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n0 = n_done;
        repeat (20) @(negedge clk);
        chk("held_across_rst", 64'(n_done), 64'(n0));
        button = 1'b0;
        repeat (8) @(negedge clk);
        issue(5, 8'h12, 8'h40);

        for (int k = 0; k < 40; k++) begin
            int f, a, b;
            f = int'($urandom_range(0, 7));
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            issue(f, a, b);
        end

        // Abort a running divide with reset.
        begin
            int n = 0;
            func = 3'd3; num1 = 8'd200; num2 = 8'd7;
            @(negedge clk); button = 1'b1;
            while (!busy && n < 50) begin @(negedge clk); n++; end
            chk("div_busy_seen", 64'(busy), 64'd1);
            repeat (3) @(negedge clk);
            n0 = n_done;
            rst = 1'b1;
            @(negedge clk);
            check_reset_state();
            rst = 1'b0;
            button = 1'b0;
            repeat (15) @(negedge clk);
            chk("abort_no_done", 64'(n_done), 64'(n0));
            chk("abort_r_zero", 64'(dut.r), 64'd0);
        end
        display_check(32'h0);
        issue(0, 8'h80, 8'h80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/calc_seg_engine.md
CALC_SEG_ENGINE -- requirements
Module: calc_seg_engine

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits (4..16).
REQ-002 SHALL have parameter NDIG, default 8, number of display digits; 4*NDIG >= 2*W.
REQ-003 SHALL have parameter SCAN_DIV, default 20000, clk cycles per displayed digit.
REQ-004 SHALL have parameter DEB_CYC, default 200000, button stable cycles for acceptance.
REQ-005 SHALL have port clk  input  1  sole clock; one clock domain.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port button  input  1  asynchronous raw start key, active-high.
REQ-008 SHALL have port func  input  3  operation select, sampled at start.
REQ-009 SHALL have ports num1, num2  input  W  unsigned operands, sampled at start.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle operation runs.
REQ-011 SHALL have port err  output  1  sticky divide-by-zero flag, cleared by next start.
REQ-012 SHALL have port led_en  output  NDIG  digit enables, active-low one-hot.
REQ-013 SHALL have ports led_ca..led_cg, led_dp  output  1 each  segments, active-low.

Function
REQ-014 SHALL pass button through a 2-flop synchroniser, then a counter that accepts a level only after DEB_CYC consecutive equal samples.
REQ-015 SHALL generate one start pulse per debounced rising edge; holding the key SHALL NOT retrigger.
REQ-016 SHALL run FSM IDLE -> EXEC -> DONE -> IDLE; start is honoured only in IDLE or DONE; start in EXEC is dropped.
REQ-017 SHALL latch func, num1, num2 on the start cycle; later input changes SHALL NOT affect the result.
REQ-018 SHALL encode func: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 shl.
REQ-019 SHALL produce result R of width 4*NDIG, zero-extended unless stated otherwise.
REQ-020 add: R = num1+num2 with carry in bit W; sub: R = num1-num2 sign-extended two's complement.
REQ-021 mul: shift-add, one bit per cycle, W cycles in EXEC, R = full 2W-bit product.
REQ-022 div: restoring, W cycles; R[2W-1:W] = quotient, R[W-1:0] = remainder.
REQ-023 div with num2 = 0: no EXEC iterations; R = all ones (4*NDIG bits); err = 1.
REQ-024 shl: R = num1 << num2[3:0], truncated to 4*NDIG bits.
REQ-025 logic ops and add/sub/shl: R valid 1 cycle after start (EXEC lasts 1 cycle); busy stays 0.
REQ-026 mul/div: busy = 1 from the cycle after start for exactly W cycles; R updates once, on the busy falling edge.
REQ-027 R SHALL hold its value in DONE and IDLE until the next completion; no partial results visible.
REQ-028 display SHALL scan digits 0..NDIG-1 cyclically, SCAN_DIV cycles each; digit i shows hex R[4i+3:4i].
REQ-029 segment map: standard hex 0-F glyphs; led_dp = 1 (off) always.
REQ-030 scan counter and digit index SHALL wrap to 0 after SCAN_DIV-1 and NDIG-1 respectively.

Reset
REQ-031 rst SHALL force FSM IDLE, R = 0, busy = 0, err = 0, debounce state = released, scan digit 0.
REQ-032 after rst: led_en = all ones except bit 0 low; segments show glyph 0.
REQ-033 rst during EXEC SHALL abort the operation; no result written.
REQ-034 button held high across rst release SHALL NOT generate a start until released and pressed again.

Structure
REQ-035 package calc_pkg SHALL hold func encodings, FSM state type and the 16-entry segment table.
REQ-036 sub-module seg_scan (params NDIG, SCAN_DIV; inputs clk, rst, value) SHALL own scanning and decoding.
REQ-037 arithmetic, debounce and FSM SHALL reside in calc_seg_engine.

Verification (W=8, NDIG=8, SCAN_DIV=4, DEB_CYC=3)
REQ-038 add 0xFF+0x01, press -> R = 0x00000100, busy never high, digit 2 shows "1".
REQ-039 mul 0xFF*0xFF -> busy high exactly 8 cycles, then R = 0x0000FE01.
REQ-040 div 200/7 -> R = 0x00001C04; div 5/0 -> R = 0xFFFFFFFF, err = 1; next add clears err.
REQ-041 sub 3-5 -> R = 0xFFFFFFFE; second press during mul EXEC ignored, result unchanged.
REQ-042 button bounces 1-2 cycles -> no start; stable 3+ cycles -> exactly one start.
REQ-043 rst mid-div -> busy = 0, R = 0, led_en = 0xFE next cycle; scan order 0..7 wraps.
